// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side and decode-side valid/ready channels of the decode/issue queue.
// Signal names keep their original prefixes so existing hookups stay valid.
interface decode_issue_ctrl_if;
    logic        i_f_valid;
    logic        o_f_ready;
    logic [31:0] i_f_instr;
    logic [31:0] i_f_pc;
    logic        o_d_valid;
    logic        i_d_ready;
    logic [31:0] o_d_instr;
    logic [31:0] o_d_pc;

    // Fetch/decode environment driving the queue
    modport master (
        output i_f_valid, i_f_instr, i_f_pc, i_d_ready,
        input  o_f_ready, o_d_valid, o_d_instr, o_d_pc
    );

    // The queue itself
    modport slave (
        input  i_f_valid, i_f_instr, i_f_pc, i_d_ready,
        output o_f_ready, o_d_valid, o_d_instr, o_d_pc
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Fetch->decode instruction queue with load-use hazard hold, flush drain and a
// saturating hazard-stall cycle counter.
module decode_issue_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    decode_issue_ctrl_if.slave     bus,
    input  logic                   i_flush,
    input  logic                   i_ex_load,
    input  logic [4:0]             i_ex_load_rd,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [CNT_W-1:0]       o_stall_cnt
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    occ_e          occ;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       hz;
    logic       push;
    logic       pop;
    logic       stall_inc;

    // Classify occupancy from the entry count
    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == FULL_CNT) begin
            occ = OCC_FULL;
        end
    end

    // Decode head operands and detect a load-use hazard against EX
    always_comb begin
        opcode   = instr_q[rd_ptr][6:0];
        rs1      = instr_q[rd_ptr][19:15];
        rs2      = instr_q[rd_ptr][24:20];
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
            7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            default: ;
        endcase
        hz = i_ex_load && (i_ex_load_rd != 5'd0) &&
             ((uses_rs1 && (rs1 == i_ex_load_rd)) || (uses_rs2 && (rs2 == i_ex_load_rd)));
    end

    // Handshakes; flush blocks both sides in the cycle it is asserted
    always_comb begin
        bus.o_f_ready = (occ != OCC_FULL) && !i_flush;
        bus.o_d_valid = (occ != OCC_EMPTY) && !hz && !i_flush;
        bus.o_d_instr = instr_q[rd_ptr];
        bus.o_d_pc    = pc_q[rd_ptr];
        push          = bus.i_f_valid && bus.o_f_ready;
        pop           = bus.o_d_valid && bus.i_d_ready;
        stall_inc     = (occ != OCC_EMPTY) && hz && !i_flush;
    end

    assign o_count = count;

    // Entry storage; reset fills every slot with a NOP at pc 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= NOP;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr] <= bus.i_f_instr;
            pc_q[wr_ptr]    <= bus.i_f_pc;
        end
    end

    // Pointers and occupancy; flush overrides any push/pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Saturating count of cycles the head was held by a hazard
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (stall_inc && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

    // A refused fetch offer must be held unchanged until accepted or flushed
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (bus.i_f_valid && !bus.o_f_ready && !i_flush) |=>
        (bus.i_f_valid && $stable(bus.i_f_instr) && $stable(bus.i_f_pc)));
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model.
module tb_decode_issue_ctrl;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SMAX  = (1 << CNT_W) - 1;

    localparam logic [31:0] I_ADDI = 32'h0010_0093; // addi x1,x0,1
    localparam logic [31:0] I_ADD  = 32'h0022_80B3; // add  x1,x5,x2
    localparam logic [31:0] I_LUI  = 32'h0002_82B7; // lui  x5 (rs1 field = 5)
    localparam logic [31:0] I_ADD0 = 32'h0000_00B3; // add  x1,x0,x0
    localparam logic [31:0] I_SW   = 32'h0033_A023; // sw   x3,0(x7)

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic [1:0]  count;
    logic [3:0]  stall;

    decode_issue_ctrl_if bif ();

    decode_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bif),
        .i_flush      (flush),
        .i_ex_load    (ex_load),
        .i_ex_load_rd (ex_rd),
        .o_count      (count),
        .o_stall_cnt  (stall)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;
    ent_t        q[$];
    int unsigned stall_m = 0;
    bit          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit model_hz(input logic [31:0] ins, input bit exl, input logic [4:0] rd);
        bit r1;
        bit r2;
        logic [6:0] op;
        op = ins[6:0];
        r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return exl && (rd != 5'd0) &&
               ((r1 && ins[19:15] == rd) || (r2 && ins[24:20] == rd));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        logic [31:0] w;
        ops = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 8)];
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // One clock cycle: drive, check combinational outputs vs model, clock, update model
    task automatic step(input bit fv, input logic [31:0] fi, input logic [31:0] fp,
                        input bit dr, input bit fl, input bit exl, input logic [4:0] rd);
        int unsigned sz;
        bit hz_m, rdy_m, dv_m;
        ent_t e;
        bif.i_f_valid = fv;
        bif.i_f_instr = fi;
        bif.i_f_pc    = fp;
        bif.i_d_ready = dr;
        flush   = fl;
        ex_load = exl;
        ex_rd   = rd;
        #1;
        sz    = q.size();
        hz_m  = (sz != 0) && model_hz(q[0].instr, exl, rd);
        rdy_m = (sz != DEPTH) && !fl;
        dv_m  = (sz != 0) && !hz_m && !fl;
        chk("count",   64'(count),         64'(sz));
        chk("f_ready", 64'(bif.o_f_ready), 64'(rdy_m));
        chk("d_valid", 64'(bif.o_d_valid), 64'(dv_m));
        chk("stall",   64'(stall),         64'(stall_m));
        if (sz != 0) begin
            chk("d_instr", 64'(bif.o_d_instr), 64'(q[0].instr));
            chk("d_pc",    64'(bif.o_d_pc),    64'(q[0].pc));
        end
        @(posedge clk);
        #1;
        last_acc = fv && rdy_m;
        if (fl) begin
            q.delete();
        end else begin
            if (dv_m && dr) void'(q.pop_front());
            if (last_acc) begin
                e.instr = fi;
                e.pc    = fp;
                q.push_back(e);
            end
        end
        if (hz_m && !fl && stall_m < SMAX) stall_m++;
    endtask

    initial begin
        bit          pend;
        bit          rfv;
        logic [31:0] rins;
        logic [31:0] rpc;

        // Reset state
        rst_n = 1'b0;
        bif.i_f_valid = 1'b0;
        bif.i_f_instr = '0;
        bif.i_f_pc    = '0;
        bif.i_d_ready = 1'b0;
        flush   = 1'b0;
        ex_load = 1'b0;
        ex_rd   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",   64'(count),         64'd0);
        chk("rst_d_valid", 64'(bif.o_d_valid), 64'd0);
        chk("rst_f_ready", 64'(bif.o_f_ready), 64'd1);
        chk("rst_d_instr", 64'(bif.o_d_instr), 64'h13);
        chk("rst_d_pc",    64'(bif.o_d_pc),    64'd0);
        chk("rst_stall",   64'(stall),         64'd0);
        rst_n = 1'b1;

        // Single push, issue next cycle, queue empties
        step(1, I_ADDI, 32'h100, 1, 0, 0, 0);
        chk("t1_d_pc", 64'(bif.o_d_pc), 64'h100);
        step(0, '0, '0, 1, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0, 0);

        // Fill to full with decode stalled; third offer waits for a slot
        step(1, I_ADDI, 32'h200, 0, 0, 0, 0);
        step(1, I_ADDI, 32'h204, 0, 0, 0, 0);
        chk("t2_full_ready", 64'(bif.o_f_ready), 64'd0);
        step(1, I_ADDI, 32'h208, 0, 0, 0, 0);
        step(1, I_ADDI, 32'h208, 1, 0, 0, 0);
        step(1, I_ADDI, 32'h208, 1, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0, 0);

        // Load-use on rs1, release, then LUI is immune
        step(1, I_ADD, 32'h300, 1, 0, 1, 5);
        repeat (3) step(0, '0, '0, 1, 0, 1, 5);
        step(0, '0, '0, 1, 0, 0, 5);
        step(1, I_LUI, 32'h304, 1, 0, 1, 5);
        step(0, '0, '0, 1, 0, 1, 5);
        step(0, '0, '0, 1, 0, 1, 5);

        // x0 destination never stalls; store stalls on rs2
        step(1, I_ADD0, 32'h400, 1, 0, 1, 0);
        step(0, '0, '0, 1, 0, 1, 0);
        step(1, I_SW, 32'h404, 1, 0, 1, 3);
        step(0, '0, '0, 1, 0, 1, 3);
        step(0, '0, '0, 1, 0, 0, 3);
        step(0, '0, '0, 1, 0, 0, 0);

        // Flush of a full queue with push and pop requested
        step(1, I_ADDI, 32'h500, 0, 0, 0, 0);
        step(1, I_ADDI, 32'h504, 0, 0, 0, 0);
        step(1, I_ADDI, 32'h508, 1, 1, 0, 0);
        chk("t5_count_after_flush", 64'(count), 64'd0);
        step(1, I_ADDI, 32'h600, 1, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0, 0);

        // Asynchronous reset with two entries queued
        step(1, I_ADDI, 32'h700, 0, 0, 0, 0);
        step(1, I_ADDI, 32'h704, 0, 0, 0, 0);
        bif.i_f_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_count",   64'(count),         64'd0);
        chk("t6_async_d_valid", 64'(bif.o_d_valid), 64'd0);
        chk("t6_async_d_instr", 64'(bif.o_d_instr), 64'h13);
        q.delete();
        stall_m = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stall counter saturation
        step(1, I_ADD, 32'h800, 1, 0, 1, 5);
        repeat (20) step(0, '0, '0, 1, 0, 1, 5);
        chk("t6_stall_sat", 64'(stall), 64'hF);
        step(0, '0, '0, 1, 1, 0, 0);

        // Randomized traffic against the model
        pend = 1'b0;
        rfv  = 1'b0;
        rins = '0;
        rpc  = '0;
        for (int n = 0; n < 400; n++) begin
            bit          rdr;
            bit          rfl;
            bit          rexl;
            logic [4:0]  rrd;
            if (!pend) begin
                rfv  = ($urandom_range(0, 3) != 0);
                rins = rand_instr();
                rpc  = $urandom & 32'hFFFF_FFFC;
            end
            rdr  = ($urandom_range(0, 2) != 0);
            rfl  = ($urandom_range(0, 15) == 0);
            rexl = ($urandom_range(0, 1) != 0);
            rrd  = 5'($urandom_range(0, 7));
            step(rfv, rins, rpc, rdr, rfl, rexl, rrd);
            pend = rfv && !last_acc && !rfl;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
